param_load_ctrl: RTL
====================

// Module: param_load_ctrl
// PURPOSE
//   Parametrised top-level sequencer for the accelerator. On start it reads NUM_PARAMS
//   words from the parameter single-port RAM, validates them and holds them on a flat
//   bus. It then runs the datapath until done, and reports finish or error.
//   Sits between the host start/finish handshake, the param RAM and the compute datapath.
// PARAMETERS
//   NUM_PARAMS  3   words to load (>=1); word i is read from RAM address BASE_ADDR+i
//   DATA_W      32  param word width
//   ADDR_W      32  param RAM address width
//   BASE_ADDR   0   first param address
//   RD_LAT      1   RAM read latency in cycles (>=1)
//   CHECK_ZERO  1   1: any zero param aborts to ERR; 0: no check
// PORTS
//   clk           in   1                  clock
//   rst           in   1                  async reset, active-high
//   start         in   1                  level; sampled only in IDLE
//   abort         in   1                  cancel in LOAD/DRAIN/RUN
//   done          in   1                  datapath complete; sampled only in RUN
//   run           out  1                  datapath enable, =1 exactly while in RUN
//   busy          out  1                  =1 in every state except IDLE
//   finish        out  1                  1-cycle pulse in FIN
//   error         out  1                  sticky zero-param flag
//   params_valid  out  1                  params hold a checked, complete set
//   params        out  NUM_PARAMS*DATA_W  word i at [i*DATA_W +: DATA_W]
//   state         out  3                  current state encoding, for debug
//   ram_cs        out  1                  param RAM chip select
//   ram_oe        out  1                  param RAM output enable
//   ram_wreq      out  1                  tied 0; this block never writes the RAM
//   ram_addr      out  ADDR_W             param RAM read address
//   ram_wdata     out  DATA_W             tied 0
//   ram_rdata     in   DATA_W             param RAM read data
// BEHAVIOUR
// - Reset: forces state IDLE. All outputs 0, params 0, counters 0, ram_addr = BASE_ADDR.
//   Reset asserted mid-operation does the same with no finish pulse.
// - States: IDLE, LOAD, DRAIN, CHECK, RUN, FIN, ERR.
// - IDLE: start=1 -> LOAD. On that edge: error<=0, params_valid<=0, issue_cnt<=0.
// - LOAD: one read per cycle. ram_cs=ram_oe=1 and ram_addr=BASE_ADDR+issue_cnt,
//   with the sum taken modulo 2^ADDR_W (wraps). issue_cnt increments each cycle.
//   After the read with issue_cnt=NUM_PARAMS-1, go to DRAIN. LOAD lasts exactly
//   NUM_PARAMS cycles. Outside LOAD: ram_cs=ram_oe=0 and ram_addr holds its last value.
// - Capture: a read issued on cycle t writes ram_rdata into params[idx] at edge t+RD_LAT.
//   Tracked by an RD_LAT-deep pipeline of valid bits and indices. Reads complete in
//   order, so capture continues into DRAIN.
// - DRAIN: lasts RD_LAT cycles, then CHECK.
// - CHECK: 1 cycle.
//   - CHECK_ZERO=1 and any word == 0 -> ERR.
//   - Otherwise -> RUN, with params_valid<=1.
// - RUN: run=1. done=1 -> FIN. abort=1 -> IDLE.
//   If done and abort are both 1 in the same cycle, abort wins: IDLE, no finish.
// - abort in LOAD or DRAIN -> IDLE next cycle. Partial params stay, params_valid=0,
//   no finish pulse. abort has no effect in IDLE, CHECK, FIN or ERR.
// - FIN: finish=1 for one cycle, then IDLE. params and params_valid are held until the
//   next accepted start.
// - ERR: error<=1, finish=1 for one cycle, then IDLE. error stays 1 until the next
//   accepted start.
// - start outside IDLE is ignored. done outside RUN is ignored.
//   If start is still high on return to IDLE, a new run begins.
// - Timing: start seen at edge 0 gives run=1 on cycle NUM_PARAMS+RD_LAT+2.
// - All outputs are registered or decoded from the state register.
//   No combinational path from any input to any output.
// TESTING
// 1 Defaults; RAM[0..2]=4,5,6; start pulse, done at 5th RUN cycle
//   -> addr 0,1,2 on consecutive cycles; params={6,5,4}; run on cycle 6; finish 1 pulse.
// 2 RD_LAT=3, NUM_PARAMS=5, RAM=1..5 -> params word i = i+1;
//   DRAIN 3 cycles; run on cycle 10.
// 3 RAM[1]=0, CHECK_ZERO=1 -> ERR; error=1, finish pulse, run never 1.
//   Next start with RAM[1]=7 -> error clears on start, normal completion.
// 4 abort on 2nd LOAD cycle -> IDLE next cycle, params_valid=0, no finish.
//   Also: abort and done together in RUN -> IDLE, no finish.
// 5 ADDR_W=4, BASE_ADDR=14, NUM_PARAMS=3 -> ram_addr sequence 14,15,0.
// 6 rst asserted mid-RUN -> all outputs 0 immediately (async).
//   start held high through FIN -> second run starts directly from IDLE.

Source files
------------

// File: rtl/param_load_ctrl.sv
// param_load_ctrl
//   Top-level sequencer for the accelerator. When start is accepted it reads
//   NUM_PARAMS words from the parameter RAM (BASE_ADDR upward, wrapping
//   modulo 2^ADDR_W). It validates the words against zero when CHECK_ZERO is
//   set, then holds them on a flat bus. It enables the datapath until done
//   and reports finish or error.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start          level request, sampled only in IDLE
//   abort          cancel while in LOAD, DRAIN or RUN
//   done           datapath complete, sampled only in RUN
//   run            datapath enable (state == RUN)
//   busy           high in every state except IDLE
//   finish         one-cycle pulse in FIN or ERR
//   error          sticky zero-parameter flag, cleared by an accepted start
//   params_valid   params hold a checked, complete set
//   params         word i at [i*DATA_W +: DATA_W]
//   state          current state encoding (debug)
//   ram_*          single-port parameter RAM, read-only use
module param_load_ctrl #(
    parameter int unsigned       NUM_PARAMS = 3,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       RD_LAT     = 1,
    parameter bit                CHECK_ZERO = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         done,
    output logic                         run,
    output logic                         busy,
    output logic                         finish,
    output logic                         error,
    output logic                         params_valid,
    output logic [NUM_PARAMS*DATA_W-1:0] params,
    output logic [2:0]                   state,
    output logic                         ram_cs,
    output logic                         ram_oe,
    output logic                         ram_wreq,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam int unsigned CW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
    localparam int unsigned DW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] LAST_IDX   = CW'(NUM_PARAMS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);

    logic [2:0]                   r_state;
    logic [CW-1:0]                r_issue_cnt;
    logic [DW-1:0]                r_drain_cnt;
    logic [ADDR_W-1:0]            r_addr;
    logic [NUM_PARAMS*DATA_W-1:0] r_params;
    logic                         r_error;
    logic                         r_params_valid;
    logic [RD_LAT-1:0]            r_pipe_v;
    logic [CW-1:0]                r_pipe_idx [RD_LAT];
    logic                         w_any_zero;

    always_comb begin
        w_any_zero = 1'b0;
        for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
            if (r_params[i*DATA_W +: DATA_W] == '0) begin
                w_any_zero = 1'b1;
            end
        end
    end

    // Read-return tracker: each LOAD cycle pushes its word index in, and the
    // entry leaving the last stage names the word that ram_rdata carries now.
    // In-flight reads keep draining after an abort so partial words land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_v <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                r_pipe_idx[k] <= '0;
            end
            r_params <= '0;
        end else begin
            r_pipe_v[0]   <= (r_state == S_LOAD);
            r_pipe_idx[0] <= r_issue_cnt;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                r_pipe_v[k]   <= r_pipe_v[k-1];
                r_pipe_idx[k] <= r_pipe_idx[k-1];
            end
            if (r_pipe_v[RD_LAT-1]) begin
                r_params[r_pipe_idx[RD_LAT-1]*DATA_W +: DATA_W] <= ram_rdata;
            end
        end
    end

    // r_addr tracks BASE_ADDR + issue_cnt while loading and simply stops
    // advancing otherwise, so it holds the last issued address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_issue_cnt    <= '0;
            r_drain_cnt    <= '0;
            r_addr         <= BASE_ADDR;
            r_error        <= 1'b0;
            r_params_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state        <= S_LOAD;
                        r_error        <= 1'b0;
                        r_params_valid <= 1'b0;
                        r_issue_cnt    <= '0;
                        r_addr         <= BASE_ADDR;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_issue_cnt == LAST_IDX) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
                    end else begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                        r_addr      <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (CHECK_ZERO && w_any_zero) begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                    end else begin
                        r_state        <= S_RUN;
                        r_params_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (done) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign run          = (r_state == S_RUN);
    assign busy         = (r_state != S_IDLE);
    assign finish       = (r_state == S_FIN) || (r_state == S_ERR);
    assign error        = r_error;
    assign params_valid = r_params_valid;
    assign params       = r_params;
    assign state        = r_state;
    assign ram_cs       = (r_state == S_LOAD);
    assign ram_oe       = (r_state == S_LOAD);
    assign ram_wreq     = 1'b0;
    assign ram_addr     = r_addr;
    assign ram_wdata    = '0;

endmodule
